// File: rtl/stream_transposer_pkg.sv
// Shared types for the ping-pong matrix transposer.
// Holds the element width rule and the per-bank state encoding.
package stream_transposer_pkg;

    localparam int DEF_IL = 4;
    localparam int DEF_FL = 16;

    function automatic int elem_width(input int il, input int fl);
        return il + fl;
    endfunction

    localparam int DEF_W = elem_width(DEF_IL, DEF_FL);

    typedef logic signed [DEF_W-1:0] elem_t;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_t;

    // A bank counts toward occupancy once it has been closed by the writer.
    function automatic logic bank_holds(input bank_state_t s);
        return (s == FULL) || (s == DRAINING);
    endfunction

endpackage

// File: rtl/transposer_bank.sv
// One ROWS x COLS matrix store: whole rows written in, whole columns read out.
// Storage is intentionally not reset.
module transposer_bank
    import stream_transposer_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int ROWS = 16,
    parameter int COLS = 256
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(ROWS)-1:0]    wr_row,
    input  logic [COLS*W-1:0]          wr_data,
    input  logic [$clog2(COLS)-1:0]    rd_col,
    output logic [ROWS*W-1:0]          rd_data
);

    logic signed [W-1:0] mem [ROWS][COLS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < COLS; j++) begin
                mem[wr_row][j] <= wr_data[j*W +: W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            rd_data[i*W +: W] = mem[i][rd_col];
        end
    end

endmodule

// File: rtl/stream_transposer.sv
// Streaming matrix transposer: rows in, columns out, through two ping-pong banks.
// Writer fills banks alternately; reader drains them in the same order.
module stream_transposer
    import stream_transposer_pkg::*;
#(
    parameter int IL   = 4,
    parameter int FL   = 16,
    parameter int ROWS = 16,
    parameter int COLS = 256,
    localparam int W   = elem_width(IL, FL)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [COLS*W-1:0]   in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ROWS*W-1:0]   out_data,
    output logic                out_last,
    output logic [1:0]          occupancy,
    output logic                frame_err,
    input  logic                err_clear
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    bank_state_t        state     [2];
    bank_state_t        state_nxt [2];
    logic [RW-1:0]      wr_row;
    logic [CW-1:0]      rd_col;
    logic               wr_bank;
    logic               rd_bank;
    logic               run;
    logic               wr_fire;
    logic               rd_fire;
    logic               wr_close;
    logic               rd_free;
    logic [ROWS*W-1:0]  rd_data [2];

    assign wr_fire  = in_valid && in_ready;
    assign rd_fire  = out_valid && out_ready;
    assign wr_close = (wr_row == ROW_LAST);
    assign rd_free  = (rd_col == COL_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state[0] <= EMPTY;
            state[1] <= EMPTY;
        end else begin
            state[0] <= state_nxt[0];
            state[1] <= state_nxt[1];
        end
    end

    // Writer and reader never touch the same bank, so both updates can land together.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_nxt[b] = state[b];
            if (wr_fire && (wr_bank == 1'(b))) begin
                state_nxt[b] = wr_close ? FULL : FILLING;
            end
            if (rd_fire && (rd_bank == 1'(b))) begin
                state_nxt[b] = rd_free ? EMPTY : DRAINING;
            end
        end
    end

    always_comb begin
        in_ready  = run && !bank_holds(state[wr_bank]);
        out_valid = bank_holds(state[rd_bank]);
        out_last  = out_valid && rd_free;
        occupancy = {1'b0, bank_holds(state[0])} + {1'b0, bank_holds(state[1])};
        out_data  = rd_data[rd_bank];
    end

    // run holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run       <= 1'b0;
            wr_row    <= '0;
            rd_col    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            run <= 1'b1;
            if (wr_fire) begin
                wr_row <= wr_close ? '0 : wr_row + RW'(1);
                if (wr_close) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (rd_fire) begin
                rd_col <= rd_free ? '0 : rd_col + CW'(1);
                if (rd_free) begin
                    rd_bank <= ~rd_bank;
                end
            end
            if (wr_fire && (in_last != wr_close)) begin
                frame_err <= 1'b1;
            end else if (err_clear) begin
                frame_err <= 1'b0;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        transposer_bank #(
            .W    (W),
            .ROWS (ROWS),
            .COLS (COLS)
        ) u_bank (
            .clk     (clk),
            .wr_en   (wr_fire && (wr_bank == 1'(b))),
            .wr_row  (wr_row),
            .wr_data (in_data),
            .rd_col  (rd_col),
            .rd_data (rd_data[b])
        );
    end

endmodule

// File: tb/tb_stream_transposer.sv
// Bench for stream_transposer with ROWS=2, COLS=3: directed scenarios plus
// randomized traffic compared every cycle against a queue-based transpose model.
module tb_stream_transposer;

    localparam int IL   = 4;
    localparam int FL   = 16;
    localparam int W    = IL + FL;
    localparam int ROWS = 2;
    localparam int COLS = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [COLS*W-1:0]   in_data = '0;
    logic                in_last = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [ROWS*W-1:0]   out_data;
    logic                out_last;
    logic [1:0]          occupancy;
    logic                frame_err;
    logic                err_clear = 1'b0;

    int checks = 0;
    int errors = 0;

    stream_transposer #(
        .IL   (IL),
        .FL   (FL),
        .ROWS (ROWS),
        .COLS (COLS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .occupancy (occupancy),
        .frame_err (frame_err),
        .err_clear (err_clear)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [ROWS*W-1:0] data;
        logic              last;
    } beat_t;

    beat_t             q[$];
    logic [COLS*W-1:0] cur [ROWS];
    int                cnt   = 0;
    bit                m_run = 1'b0;
    bit                m_fe  = 1'b0;

    // Matrices still owed to the sink, counting a partly drained one.
    function automatic int m_occ();
        return (q.size() + COLS - 1) / COLS;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            q.delete();
            cnt   = 0;
            m_run = 1'b0;
            m_fe  = 1'b0;
        end else begin
            bit    acc_in;
            bit    acc_out;
            beat_t bt;
            acc_in  = in_valid && m_run && (m_occ() < 2);
            acc_out = (q.size() > 0) && out_ready;
            if (acc_out) void'(q.pop_front());
            if (acc_in && (in_last != (cnt == ROWS - 1))) m_fe = 1'b1;
            else if (err_clear) m_fe = 1'b0;
            if (acc_in) begin
                cur[cnt] = in_data;
                cnt++;
                if (cnt == ROWS) begin
                    for (int c = 0; c < COLS; c++) begin
                        for (int r = 0; r < ROWS; r++) begin
                            bt.data[r*W +: W] = cur[r][c*W +: W];
                        end
                        bt.last = (c == COLS - 1);
                        q.push_back(bt);
                    end
                    cnt = 0;
                end
            end
            m_run = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_run && (m_occ() < 2));
        chk("out_valid", out_valid, q.size() > 0);
        chk("occupancy", occupancy, m_occ());
        chk("frame_err", frame_err, m_fe);
        if (q.size() > 0) begin
            chk("out_data", out_data, q[0].data);
            chk("out_last", out_last, q[0].last);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [COLS*W-1:0] row3(input int a, input int b, input int c);
        return {W'(c), W'(b), W'(a)};
    endfunction

    function automatic logic [ROWS*W-1:0] col2(input int a, input int b);
        return {W'(b), W'(a)};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [COLS*W-1:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int k = 0; k < 64; k++) begin
            if (in_ready) begin
                step();
                in_valid = 1'b0;
                return;
            end
            step();
        end
        chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        out_ready = 1'b1;
        for (int k = 0; k < 40 && out_valid; k++) step();
        chk(nm, out_valid, 64'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 64'd0);
        chk("rst_out_valid", out_valid, 64'd0);
        chk("rst_out_last", out_last, 64'd0);
        chk("rst_occupancy", occupancy, 64'd0);
        chk("rst_frame_err", frame_err, 64'd0);
        step();
        step();
        reset = 1'b1;
        chk("rel_in_ready_low", in_ready, 64'd0);
        step();
        chk("rel_in_ready_high", in_ready, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        chk("init_in_ready", in_ready, 64'd0);
        chk("init_occupancy", occupancy, 64'd0);
        chk("init_out_valid", out_valid, 64'd0);
        reset = 1'b1;
        step();
        chk("init_ready_after_release", in_ready, 64'd1);

        // Back-to-back 2x3 matrix with an always-ready sink.
        out_ready = 1'b1;
        send(row3(1, 2, 3), 1'b0);
        send(row3(4, 5, 6), 1'b1);
        chk("basic_occ", occupancy, 64'd1);
        chk("basic_c0", out_data, col2(1, 4));
        chk("basic_l0", out_last, 64'd0);
        step();
        chk("basic_c1", out_data, col2(2, 5));
        step();
        chk("basic_c2", out_data, col2(3, 6));
        chk("basic_l2", out_last, 64'd1);
        step();
        chk("basic_done", out_valid, 64'd0);

        // Framing error: in_last on row 0, data still transposed.
        send(row3(1, 2, 3), 1'b1);
        send(row3(4, 5, 6), 1'b1);
        chk("ferr_set", frame_err, 64'd1);
        chk("ferr_c0", out_data, col2(1, 4));
        step();
        chk("ferr_c1", out_data, col2(2, 5));
        step();
        chk("ferr_c2", out_data, col2(3, 6));
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("ferr_cleared", frame_err, 64'd0);

        // Three matrices against a stalled sink.
        out_ready = 1'b0;
        send(row3(10, 11, 12), 1'b0);
        send(row3(13, 14, 15), 1'b1);
        send(row3(-20, 21, -22), 1'b0);
        send(row3(23, -24, 25), 1'b1);
        chk("full_in_ready", in_ready, 64'd0);
        chk("full_occ", occupancy, 64'd2);
        in_valid = 1'b1;
        in_data  = row3(30, 31, 32);
        in_last  = 1'b0;
        repeat (3) step();
        chk("full_still_blocked", in_ready, 64'd0);
        chk("full_m1_c0", out_data, col2(10, 13));
        out_ready = 1'b1;
        send(row3(30, 31, 32), 1'b0);
        send(row3(33, 34, 35), 1'b1);
        drain("full_drained");

        // Writer closes a bank on the same edge the reader frees the other.
        send(row3(40, 41, 42), 1'b0);
        send(row3(43, 44, 45), 1'b1);
        step();
        send(row3(50, 51, 52), 1'b0);
        chk("xover_last_col", out_last, 64'd1);
        send(row3(53, 54, 55), 1'b1);
        chk("xover_occ", occupancy, 64'd1);
        chk("xover_valid", out_valid, 64'd1);
        chk("xover_m2_c0", out_data, col2(50, 53));
        drain("xover_drained");

        // Reset mid-matrix, then mid-drain.
        send(row3(60, 61, 62), 1'b0);
        pulse_reset();
        send(row3(7, 8, 9), 1'b0);
        send(row3(10, 11, 12), 1'b1);
        step();
        chk("rst_mid_drain_c1", out_data, col2(8, 11));
        pulse_reset();
        send(row3(-1, 2, -3), 1'b0);
        send(row3(4, -5, 6), 1'b1);
        chk("after_rst_c0", out_data, col2(-1, 4));
        drain("after_rst_drained");

        // Randomized traffic: toggling sink first, then random back-pressure.
        for (int n = 0; n < 800; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < COLS; c++) in_data[c*W +: W] = W'($urandom);
            in_last   = (cnt == ROWS - 1) ^ ($urandom_range(0, 19) == 0);
            out_ready = (n < 200) ? (n % 2 == 0) : ($urandom_range(0, 2) != 0);
            err_clear = ($urandom_range(0, 15) == 0);
            step();
        end
        in_valid  = 1'b0;
        err_clear = 1'b0;
        drain("final_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
